booth_multiple_gen: RTL and testbench

BOOTH_MULTIPLE_GEN -- requirements
Module: booth_multiple_gen

---
 rtl/booth_multiple_gen.sv | 110 +++++++++++
 tb/tb_booth_multiple_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_multiple_gen.sv
// Two-stage generator of the signed multiples 1A..NUM_MULT*A used by a radix-4/radix-8 Booth multiplier.
// Optional build macro BOOTH_MULTIPLE_GEN_NEG_EN adds the registered negative multiples on mult_neg_o.
module booth_multiple_gen #(
    parameter int SIZE     = 18,
    parameter int NUM_MULT = 4,
    localparam int OUT_W   = SIZE + $clog2(NUM_MULT)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [SIZE-1:0]              in_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic [NUM_MULT*OUT_W-1:0]    mult_o,
`ifdef BOOTH_MULTIPLE_GEN_NEG_EN
    output logic [NUM_MULT*(OUT_W+1)-1:0] mult_neg_o,
`endif
    output logic                         out_valid_o,
    input  logic                         out_ready_i
);

    logic                    s1_valid_r;
    logic                    s2_valid_r;
    logic signed [OUT_W-1:0] s1_data_r;
    logic                    s1_en_s;
    logic                    s2_en_s;
    logic signed [OUT_W-1:0] mult_s [NUM_MULT];
    logic [NUM_MULT*OUT_W-1:0] mult_r;

    // S2 loads whenever it is empty or being drained; S1 follows S2 so no bubble forms.
    assign s2_en_s    = !s2_valid_r || out_ready_i;
    assign s1_en_s    = !s1_valid_r || s2_en_s;
    assign in_ready_o = s1_en_s;

    // Pipeline occupancy; reset beats flush, flush beats a simultaneous accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else if (flush_i) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (s1_en_s) begin
                s1_valid_r <= in_valid_i;
            end
            if (s2_en_s) begin
                s2_valid_r <= s1_valid_r;
            end
        end
    end

    // S1 data: sign-extend A to the full output width so later shifts never overflow.
    always_ff @(posedge clk_i) begin
        if (s1_en_s) begin
            s1_data_r <= OUT_W'($signed(in_i));
        end
    end

    assign mult_s[0] = s1_data_r;
    assign mult_s[1] = s1_data_r <<< 1;
    assign mult_s[2] = (s1_data_r <<< 1) + s1_data_r;
    assign mult_s[3] = s1_data_r <<< 2;

    if (NUM_MULT == 8) begin : g_mult8
        // 7A as 8A - A keeps every odd multiple to a single adder.
        assign mult_s[4] = (s1_data_r <<< 2) + s1_data_r;
        assign mult_s[5] = mult_s[2] <<< 1;
        assign mult_s[6] = (s1_data_r <<< 3) - s1_data_r;
        assign mult_s[7] = s1_data_r <<< 3;
    end

    // S2 register for the positive multiples, held while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mult_r <= {(NUM_MULT*OUT_W){1'b0}};
        end else if (s2_en_s) begin
            for (int k = 0; k < NUM_MULT; k++) begin
                mult_r[k*OUT_W +: OUT_W] <= mult_s[k];
            end
        end
    end

    assign mult_o      = mult_r;
    assign out_valid_o = s2_valid_r;

`ifdef BOOTH_MULTIPLE_GEN_NEG_EN
    logic signed [OUT_W:0]         neg_s [NUM_MULT];
    logic [NUM_MULT*(OUT_W+1)-1:0] neg_r;

    // One extra bit so that negating the most negative multiple stays exact.
    for (genvar g = 0; g < NUM_MULT; g++) begin : g_neg
        assign neg_s[g] = -((OUT_W+1)'(mult_s[g]));
    end

    // S2 register for the negative multiples, same enable as mult_r.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            neg_r <= {(NUM_MULT*(OUT_W+1)){1'b0}};
        end else if (s2_en_s) begin
            for (int k = 0; k < NUM_MULT; k++) begin
                neg_r[k*(OUT_W+1) +: (OUT_W+1)] <= neg_s[k];
            end
        end
    end

    assign mult_neg_o = neg_r;
`endif

endmodule

// File: tb/tb_booth_multiple_gen.sv
// Bench for booth_multiple_gen: queue-based scoreboard checked every cycle plus directed literal checks,
// on a NUM_MULT=4 and a NUM_MULT=8 instance sharing one stimulus.
module tb_booth_multiple_gen;
    localparam int SZ = 18;
    localparam int W4 = 20;
    localparam int W8 = 21;

    logic          clk = 1'b0;
    logic          rst_i, flush_i, in_valid_i, out_ready_i;
    logic [SZ-1:0] in_i;
    logic          in_ready4, out_valid4, in_ready8, out_valid8;
    logic [4*W4-1:0] mult4;
    logic [8*W8-1:0] mult8;
    logic [W8-1:0]   slice8;
`ifdef BOOTH_MULTIPLE_GEN_NEG_EN
    logic [4*(W4+1)-1:0] neg4;
    logic [8*(W8+1)-1:0] neg8;
    logic [W4:0]         slice_n4;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;
    int                  q_t[$];
    logic signed [SZ-1:0] q_a[$];
    logic signed [SZ-1:0] vals [10];
    logic [15:0] rdy_pat = 16'b1011_0011_1101_0110;
    logic [15:0] vld_pat = 16'b1110_1101_1011_1111;

    booth_multiple_gen #(.SIZE(SZ), .NUM_MULT(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .in_i(in_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready4), .mult_o(mult4),
`ifdef BOOTH_MULTIPLE_GEN_NEG_EN
        .mult_neg_o(neg4),
`endif
        .out_valid_o(out_valid4), .out_ready_i(out_ready_i)
    );

    booth_multiple_gen #(.SIZE(SZ), .NUM_MULT(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .in_i(in_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready8), .mult_o(mult8),
`ifdef BOOTH_MULTIPLE_GEN_NEG_EN
        .mult_neg_o(neg8),
`endif
        .out_valid_o(out_valid8), .out_ready_i(out_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_l(input string name, input int k, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s k=%0d: got %0d expected %0d", name, k, got, exp);
        end
    endtask

    // An accepted value is visible two edges after its accept and leaves when consumed.
    function automatic bit exp_valid();
        return (q_t.size() != 0) && (cyc - q_t[0] >= 2);
    endfunction

    function automatic bit exp_ready();
        return (q_t.size() < 2) || out_ready_i;
    endfunction

    // Scoreboard update on each clock edge.
    always @(posedge clk) begin
        if (rst_i) begin
            q_t.delete();
            q_a.delete();
            chk_en <= 1'b1;
        end else if (flush_i) begin
            q_t.delete();
            q_a.delete();
        end else begin
            if (exp_valid() && out_ready_i) begin
                void'(q_t.pop_front());
                void'(q_a.pop_front());
            end
            if (in_valid_i && exp_ready()) begin
                q_t.push_back(cyc);
                q_a.push_back($signed(in_i));
            end
        end
        cyc <= cyc + 1;
    end

    // Per-cycle comparison against the scoreboard, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid4", out_valid4, exp_valid());
            check("out_valid8", out_valid8, exp_valid());
            check("in_ready4", in_ready4, exp_ready());
            check("in_ready8", in_ready8, exp_ready());
            if (exp_valid() && out_valid4 && out_valid8) begin
                for (int k = 1; k <= 4; k++) begin
                    check_l("mult4", k, longint'($signed(mult4[(k-1)*W4 +: W4])), longint'(k) * longint'(q_a[0]));
`ifdef BOOTH_MULTIPLE_GEN_NEG_EN
                    check_l("neg4", k, longint'($signed(neg4[(k-1)*(W4+1) +: (W4+1)])), -longint'(k) * longint'(q_a[0]));
`endif
                end
                for (int k = 1; k <= 8; k++) begin
                    check_l("mult8", k, longint'($signed(mult8[(k-1)*W8 +: W8])), longint'(k) * longint'(q_a[0]));
`ifdef BOOTH_MULTIPLE_GEN_NEG_EN
                    check_l("neg8", k, longint'($signed(neg8[(k-1)*(W8+1) +: (W8+1)])), -longint'(k) * longint'(q_a[0]));
`endif
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vals = '{18'sd0, 18'sd1, -18'sd1, 18'sd131071, -18'sd131072,
                 18'sd12345, -18'sd54321, 18'sd2, 18'sd65536, -18'sd3};
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1; in_i = '0;
        step();
        step();
        check("rst_out_valid", out_valid4, 1'b0);
        check("rst_mult", mult4, {(4*W4){1'b0}});
        check("rst_mult8", mult8, {(8*W8){1'b0}});
        rst_i = 1'b0;
        step();
        check("post_rst_valid", out_valid4, 1'b0);
        check("post_rst_ready", in_ready4, 1'b1);

        // A = 5, two cycles of latency
        in_i = 18'sd5; in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        step();
        check("a5_valid", out_valid4, 1'b1);
        check("a5_mult", mult4, {20'sd20, 20'sd15, 20'sd10, 20'sd5});
        step();

        // Most negative A: no overflow
        in_i = 18'h20000; in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        step();
        check("amin_mult", mult4, {20'h80000, 20'hA0000, 20'hC0000, 20'hE0000});
        slice8 = mult8[7*W8 +: W8];
        check("amin_8a", slice8, 21'h100000);
`ifdef BOOTH_MULTIPLE_GEN_NEG_EN
        slice_n4 = neg4[3*(W4+1) +: (W4+1)];
        check("amin_neg4a", slice_n4, 21'h080000);
`endif
        step();

`ifdef BOOTH_MULTIPLE_GEN_NEG_EN
        in_i = 18'sd7; in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        step();
        check("a7_neg", neg4, {-21'sd28, -21'sd21, -21'sd14, -21'sd7});
        step();
`endif

        // Back-pressure: 4 cycles of out_ready low while streaming 1,2,3
        out_ready_i = 1'b0;
        in_i = 18'sd1; in_valid_i = 1'b1;
        step();
        in_i = 18'sd2;
        step();
        check("bp_valid", out_valid4, 1'b1);
        check("bp_row1", mult4, {20'sd4, 20'sd3, 20'sd2, 20'sd1});
        in_i = 18'sd3;
        check("bp_ready_low", in_ready4, 1'b0);
        step();
        step();
        check("bp_hold", mult4, {20'sd4, 20'sd3, 20'sd2, 20'sd1});
        check("bp_ready_low2", in_ready4, 1'b0);
        out_ready_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        check("bp_out2", mult4[W4-1:0], 20'sd2);
        step();
        check("bp_out3", mult4[W4-1:0], 20'sd3);
        step();
        check("bp_drained", out_valid4, 1'b0);

        // Flush with both stages full; the input offered during flush is dropped
        out_ready_i = 1'b0;
        in_i = 18'sd11; in_valid_i = 1'b1;
        step();
        in_i = 18'sd12;
        step();
        flush_i = 1'b1; in_i = 18'sd13;
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        check("flush_valid", out_valid4, 1'b0);
        check("flush_ready", in_ready4, 1'b1);
        out_ready_i = 1'b1;
        in_i = 18'sd9; in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        step();
        check("flush_a9", mult4, {20'sd36, 20'sd27, 20'sd18, 20'sd9});
        step();

        // Reset mid-stream discards in-flight data
        in_i = 18'sd20; in_valid_i = 1'b1;
        step();
        in_i = 18'sd21;
        step();
        rst_i = 1'b1; in_i = 18'sd22;
        step();
        rst_i = 1'b0; in_valid_i = 1'b0;
        check("mid_rst_valid", out_valid4, 1'b0);
        check("mid_rst_mult", mult4, {(4*W4){1'b0}});
        step();
        step();
        step();
        check("mid_rst_no_stale", out_valid4, 1'b0);

        // Directed stream with mixed valid/ready patterns
        for (int i = 0; i < 48; i++) begin
            in_i        = vals[i % 10];
            in_valid_i  = vld_pat[i % 16];
            out_ready_i = rdy_pat[(i * 3) % 16];
            step();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("stream_drained", out_valid4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
